// File: rtl/lgu_pkg.sv
// rtl/lgu_pkg.sv - shared op-code constants for the logic gate unit
package lgu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } lgu_op_e;

endpackage

// File: rtl/lgu_alu.sv
// rtl/lgu_alu.sv - combinational bitwise operation with optional OR-reduce
module lgu_alu
  import lgu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             red,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r;

  always_comb begin
    r = a;
    case (lgu_op_e'(op))
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: r = a;
    endcase
  end

  // Indexed bit write keeps WIDTH=1 legal (no zero-width concatenation).
  always_comb begin
    value = r;
    if (red) begin
      value    = '0;
      value[0] = |r;
    end
  end

endmodule

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - valid/ready wrapped logic unit with output register and transfer counter
module logic_gate_unit
  import lgu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             red,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] cnt
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_value;
  logic             accept;
  logic             xfer;

  lgu_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (a),
    .b     (b),
    .op    (op),
    .red   (red),
    .value (alu_value)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  // Accept is applied after transfer so a same-cycle pair keeps out_valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    if (xfer) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = alu_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cnt       = cnt_q;

endmodule
